// File: rtl/qr_pkg.sv
// Shared constants, FSM states and plane lookup for the 3x3 Givens QR sequencer.
// Data is signed Q4.12; matrix elements are indexed row-major from 0.
package qr_pkg;

  localparam int W    = 16;
  localparam int FRAC = 12;
  localparam int NE   = 9;
  localparam logic signed [W-1:0] ONE = W'(1 << FRAC);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ROT,
    DONE
  } state_t;

  localparam logic [1:0] PLANE_NONE = 2'd0;
  localparam logic [1:0] PLANE_12   = 2'd1;
  localparam logic [1:0] PLANE_13   = 2'd2;
  localparam logic [1:0] PLANE_23   = 2'd3;

  // Zero-based rows p/q and pivot column k for a rotation plane.
  typedef struct packed {
    logic [1:0] row_p;
    logic [1:0] row_q;
    logic [1:0] col_k;
  } plane_map_t;

  function automatic plane_map_t plane_map(input logic [1:0] plane);
    plane_map_t m;
    case (plane)
      PLANE_12: m = '{row_p: 2'd0, row_q: 2'd1, col_k: 2'd0};
      PLANE_13: m = '{row_p: 2'd0, row_q: 2'd2, col_k: 2'd0};
      PLANE_23: m = '{row_p: 2'd1, row_q: 2'd2, col_k: 2'd1};
      default:  m = '{row_p: 2'd0, row_q: 2'd1, col_k: 2'd0};
    endcase
    return m;
  endfunction

  function automatic logic [3:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/givens_row_update.sv
// Combinational Givens update of one column pair: p' = c*ap + s*aq, q' = c*aq - s*ap,
// rounded half-up at FRAC and saturated to the signed W-bit range.
module givens_row_update
  import qr_pkg::*;
(
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] s,
  input  logic signed [W-1:0] ap,
  input  logic signed [W-1:0] aq,
  output logic signed [W-1:0] p_new,
  output logic signed [W-1:0] q_new
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;
  localparam logic [SW-1:0]        RND  = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = (SW'(1) << (W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -(SW'(1) << (W - 1));

  logic signed [PW-1:0] c_x, s_x, ap_x, aq_x;
  logic signed [PW-1:0] c_ap, s_aq, c_aq, s_ap;
  logic signed [SW-1:0] p_sum, q_sum, p_shift, q_shift;

  assign c_x  = {{W{c[W-1]}}, c};
  assign s_x  = {{W{s[W-1]}}, s};
  assign ap_x = {{W{ap[W-1]}}, ap};
  assign aq_x = {{W{aq[W-1]}}, aq};

  assign c_ap = c_x * ap_x;
  assign s_aq = s_x * aq_x;
  assign c_aq = c_x * aq_x;
  assign s_ap = s_x * ap_x;

  assign p_sum = {c_ap[PW-1], c_ap} + {s_aq[PW-1], s_aq} + RND;
  assign q_sum = {c_aq[PW-1], c_aq} - {s_ap[PW-1], s_ap} + RND;

  assign p_shift = p_sum >>> FRAC;
  assign q_shift = q_sum >>> FRAC;

  assign p_new = (p_shift > MAXV) ? MAXV[W-1:0] :
                 (p_shift < MINV) ? MINV[W-1:0] : p_shift[W-1:0];
  assign q_new = (q_shift > MAXV) ? MAXV[W-1:0] :
                 (q_shift < MINV) ? MINV[W-1:0] : q_shift[W-1:0];

endmodule

// File: rtl/givens_qr_sequencer.sv
// Sequences the three Givens rotations of a 3x3 QR, owning the working matrix and
// sharing one external cos/sin generator through a request/response handshake.
module givens_qr_sequencer
  import qr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NE*W-1:0]   a_in,
  output logic              cs_req_valid,
  input  logic              cs_req_ready,
  output logic [W-1:0]      cs_req_x,
  output logic [W-1:0]      cs_req_y,
  input  logic              cs_rsp_valid,
  input  logic [W-1:0]      cs_rsp_cos,
  input  logic [W-1:0]      cs_rsp_sin,
  output logic [1:0]        plane,
  output logic [W-1:0]      cos1,
  output logic [W-1:0]      cos2,
  output logic [W-1:0]      cos3,
  output logic [W-1:0]      sin1,
  output logic [W-1:0]      sin2,
  output logic [W-1:0]      sin3,
  output logic [NE*W-1:0]   r_out,
  output logic              busy,
  output logic              done
);

  state_t     state_reg, state_next;
  logic [1:0] plane_reg, plane_next;
  logic [1:0] col_reg, col_next;

  logic signed [W-1:0] m_reg   [NE];
  logic signed [W-1:0] cos_reg [3];
  logic signed [W-1:0] sin_reg [3];

  plane_map_t          map;
  logic [3:0]          piv_x_idx, piv_y_idx, rot_p_idx, rot_q_idx;
  logic [1:0]          slot;
  logic signed [W-1:0] piv_x, piv_y, ap_sel, aq_sel, c_act, s_act;
  logic signed [W-1:0] p_new, q_new;
  logic                pivot_zero, cs_latch;
  logic signed [W-1:0] cs_c_sel, cs_s_sel;

  assign map       = plane_map(plane_reg);
  assign piv_x_idx = elem_idx(map.row_p, map.col_k);
  assign piv_y_idx = elem_idx(map.row_q, map.col_k);
  assign rot_p_idx = elem_idx(map.row_p, col_reg);
  assign rot_q_idx = elem_idx(map.row_q, col_reg);
  assign slot      = (plane_reg == PLANE_NONE) ? 2'd0 : plane_reg - 2'd1;

  assign piv_x      = m_reg[piv_x_idx];
  assign piv_y      = m_reg[piv_y_idx];
  assign ap_sel     = m_reg[rot_p_idx];
  assign aq_sel     = m_reg[rot_q_idx];
  assign c_act      = cos_reg[slot];
  assign s_act      = sin_reg[slot];
  assign pivot_zero = (piv_x == '0) && (piv_y == '0);

  // A zero pivot pair needs no rotation: identity coefficients stand in for the generator.
  assign cs_latch = ((state_reg == REQ) && pivot_zero) || ((state_reg == WAIT) && cs_rsp_valid);
  assign cs_c_sel = pivot_zero ? ONE : cs_rsp_cos;
  assign cs_s_sel = pivot_zero ? '0  : cs_rsp_sin;

  givens_row_update u_row_update (
    .c     (c_act),
    .s     (s_act),
    .ap    (ap_sel),
    .aq    (aq_sel),
    .p_new (p_new),
    .q_new (q_new)
  );

  always_comb begin
    state_next = state_reg;
    plane_next = plane_reg;
    col_next   = col_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          plane_next = PLANE_12;
        end
      end
      REQ: begin
        if (pivot_zero) begin
          state_next = ROT;
          col_next   = 2'd0;
        end else if (cs_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cs_rsp_valid) begin
          state_next = ROT;
          col_next   = 2'd0;
        end
      end
      ROT: begin
        if (col_reg == 2'd2) begin
          col_next = 2'd0;
          if (plane_reg == PLANE_23) begin
            state_next = DONE;
            plane_next = PLANE_NONE;
          end else begin
            state_next = REQ;
            plane_next = plane_reg + 2'd1;
          end
        end else begin
          col_next = col_reg + 2'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        plane_next = PLANE_NONE;
      end
      default: begin
        state_next = IDLE;
        plane_next = PLANE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      plane_reg <= PLANE_NONE;
      col_reg   <= 2'd0;
      for (int i = 0; i < NE; i++) m_reg[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        cos_reg[i] <= ONE;
        sin_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      plane_reg <= plane_next;
      col_reg   <= col_next;
      if ((state_reg == IDLE) && start) begin
        for (int i = 0; i < NE; i++) m_reg[i] <= a_in[i*W +: W];
      end
      if (cs_latch) begin
        cos_reg[slot] <= cs_c_sel;
        sin_reg[slot] <= cs_s_sel;
      end
      // The pivot-column entry of row q is forced to an exact zero to drop rounding residue.
      if (state_reg == ROT) begin
        m_reg[rot_p_idx] <= p_new;
        m_reg[rot_q_idx] <= (col_reg == map.col_k) ? '0 : q_new;
      end
    end
  end

  assign cs_req_valid = (state_reg == REQ) && !pivot_zero;
  assign cs_req_x     = cs_req_valid ? piv_x : '0;
  assign cs_req_y     = cs_req_valid ? piv_y : '0;
  assign plane        = plane_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

  assign cos1 = cos_reg[0];
  assign cos2 = cos_reg[1];
  assign cos3 = cos_reg[2];
  assign sin1 = sin_reg[0];
  assign sin2 = sin_reg[1];
  assign sin3 = sin_reg[2];

  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_r_out
      assign r_out[gi*W +: W] = m_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_givens_qr_sequencer.sv
// Directed bench: acts as the cos/sin generator, checks request pivots, latency, R and cos/sin.
module tb_givens_qr_sequencer;
  import qr_pkg::*;

  localparam int MW = NE * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] a_in = '0;
  logic          cs_req_valid;
  logic          cs_req_ready = 1'b0;
  logic [W-1:0]  cs_req_x, cs_req_y;
  logic          cs_rsp_valid = 1'b0;
  logic [W-1:0]  cs_rsp_cos = '0;
  logic [W-1:0]  cs_rsp_sin = '0;
  logic [1:0]    plane;
  logic [W-1:0]  cos1, cos2, cos3, sin1, sin2, sin3;
  logic [MW-1:0] r_out;
  logic          busy, done;

  givens_qr_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a_in         (a_in),
    .cs_req_valid (cs_req_valid),
    .cs_req_ready (cs_req_ready),
    .cs_req_x     (cs_req_x),
    .cs_req_y     (cs_req_y),
    .cs_rsp_valid (cs_rsp_valid),
    .cs_rsp_cos   (cs_rsp_cos),
    .cs_rsp_sin   (cs_rsp_sin),
    .plane        (plane),
    .cos1         (cos1),
    .cos2         (cos2),
    .cos3         (cos3),
    .sin1         (sin1),
    .sin2         (sin2),
    .sin3         (sin3),
    .r_out        (r_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected generator traffic and final cos/sin for the current case.
  logic [1:0]   rq_pl [3];
  logic [W-1:0] rq_x  [3];
  logic [W-1:0] rq_y  [3];
  logic [W-1:0] rs_c  [3];
  logic [W-1:0] rs_s  [3];
  logic [W-1:0] ex_cos [3];
  logic [W-1:0] ex_sin [3];
  int           n_req_exp;

  localparam logic [W-1:0] H = 16'h0B50;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [MW-1:0] mat(input logic [W-1:0] a11, a12, a13, a21, a22, a23,
                                        a31, a32, a33);
    return {a33, a32, a31, a23, a22, a21, a13, a12, a11};
  endfunction

  task automatic set_req(input int i, input logic [1:0] pl, input logic [W-1:0] x, y, c, s);
    rq_pl[i] = pl; rq_x[i] = x; rq_y[i] = y; rs_c[i] = c; rs_s[i] = s;
  endtask

  task automatic set_cs(input logic [W-1:0] c1, s1, c2, s2, c3, s3);
    ex_cos[0] = c1; ex_sin[0] = s1;
    ex_cos[1] = c2; ex_sin[1] = s2;
    ex_cos[2] = c3; ex_sin[2] = s3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r"},     r_out, '0);
    check({tag, "_cos1"},  MW'(cos1), MW'(ONE));
    check({tag, "_cos2"},  MW'(cos2), MW'(ONE));
    check({tag, "_sin1"},  MW'(sin1), '0);
    check({tag, "_ctl"},   MW'({busy, done, cs_req_valid, plane}), '0);
  endtask

  task automatic run_case(input string name, input logic [MW-1:0] a, input int stall,
                          input bit spur, input bit xstart, input int rst_at,
                          input int exp_done, input logic [MW-1:0] exp_r);
    int n = 0;
    int done_n = 0;
    int req_idx = 0;
    int stall_left = stall;
    bit acc = 1'b0;
    bit seen = 1'b0;
    bit aborted = 1'b0;
    logic [W-1:0] hx = '0;
    logic [W-1:0] hy = '0;
    @(negedge clk);
    a_in = a;
    start = 1'b1;
    while (done_n == 0 && n < 60 && !aborted) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = xstart && (n == 7);
      a_in = ~a;
      cs_rsp_valid = 1'b0;
      if (rst_at != 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs({name, "_midrst"});
        aborted = 1'b1;
      end else if (done) begin
        done_n = n;
      end else if (acc) begin
        cs_req_ready = 1'b0;
        cs_rsp_valid = 1'b1;
        cs_rsp_cos = rs_c[req_idx];
        cs_rsp_sin = rs_s[req_idx];
        req_idx++;
        acc = 1'b0;
        seen = 1'b0;
      end else if (cs_req_valid) begin
        if (!seen) begin
          seen = 1'b1;
          hx = cs_req_x;
          hy = cs_req_y;
          if (req_idx < 3) begin
            check({name, "_req_plane"}, MW'(plane), MW'(rq_pl[req_idx]));
            check({name, "_req_x"}, MW'(cs_req_x), MW'(rq_x[req_idx]));
            check({name, "_req_y"}, MW'(cs_req_y), MW'(rq_y[req_idx]));
          end
        end else begin
          check({name, "_hold_xy"}, MW'({cs_req_x, cs_req_y}), MW'({hx, hy}));
        end
        if (stall_left > 0) begin
          stall_left--;
          cs_req_ready = 1'b0;
          if (spur) begin
            cs_rsp_valid = 1'b1;
            cs_rsp_cos = 16'h1234;
            cs_rsp_sin = 16'h2345;
            spur = 1'b0;
          end
        end else begin
          cs_req_ready = 1'b1;
          acc = 1'b1;
        end
      end
    end
    start = 1'b0;
    cs_req_ready = 1'b0;
    if (!aborted) begin
      $display("case %s: done_cycle=%0d requests=%0d", name, done_n, req_idx);
      check({name, "_done_cycle"}, MW'(done_n), MW'(exp_done));
      check({name, "_n_req"}, MW'(req_idx), MW'(n_req_exp));
      check({name, "_r"}, r_out, exp_r);
      check({name, "_cos"}, MW'({cos1, cos2, cos3}), MW'({ex_cos[0], ex_cos[1], ex_cos[2]}));
      check({name, "_sin"}, MW'({sin1, sin2, sin3}), MW'({ex_sin[0], ex_sin[1], ex_sin[2]}));
      @(negedge clk);
      check({name, "_after"}, MW'({busy, done, plane}), '0);
    end else begin
      $display("case %s: reset applied at cycle %0d", name, n);
    end
  endtask

  initial begin
    logic [MW-1:0] r_t2;
    r_t2 = mat(16'h16A0, H, 0, 0, H, 0, 0, 0, ONE);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Identity: pivots are (ONE,0), generator answers identity coefficients.
    set_req(0, 2'd1, ONE, 0, ONE, 0);
    set_req(1, 2'd2, ONE, 0, ONE, 0);
    set_req(2, 2'd3, ONE, 0, ONE, 0);
    n_req_exp = 3;
    set_cs(ONE, 0, ONE, 0, ONE, 0);
    run_case("identity", mat(ONE, 0, 0, 0, ONE, 0, 0, 0, ONE), 0, 0, 0, 0, 16,
             mat(ONE, 0, 0, 0, ONE, 0, 0, 0, ONE));

    // 45-degree rotation in plane (1,2).
    set_req(0, 2'd1, ONE, ONE, H, H);
    set_req(1, 2'd2, 16'h16A0, 0, ONE, 0);
    set_req(2, 2'd3, H, 0, ONE, 0);
    n_req_exp = 3;
    set_cs(H, H, ONE, 0, ONE, 0);
    run_case("rot45", mat(ONE, 0, 0, ONE, ONE, 0, 0, 0, ONE), 0, 0, 0, 0, 16, r_t2);

    // All-zero matrix: every plane skips the handshake.
    n_req_exp = 0;
    set_cs(ONE, 0, ONE, 0, ONE, 0);
    run_case("zero", '0, 0, 0, 0, 0, 13, '0);

    // Negative result in row 2 exercises the q' subtraction.
    set_req(0, 2'd1, ONE, ONE, H, H);
    set_req(1, 2'd2, 16'h16A0, 0, ONE, 0);
    set_req(2, 2'd3, 16'hF4B0, 0, ONE, 0);
    n_req_exp = 3;
    set_cs(H, H, ONE, 0, ONE, 0);
    run_case("negq", mat(ONE, ONE, 0, ONE, 0, 0, 0, 0, ONE), 0, 0, 0, 0, 16,
             mat(16'h16A0, H, 0, 0, 16'hF4B0, 0, 0, 0, ONE));

    // Ready held low 5 cycles on the first request.
    set_req(0, 2'd1, ONE, ONE, H, H);
    set_req(1, 2'd2, 16'h16A0, 0, ONE, 0);
    set_req(2, 2'd3, H, 0, ONE, 0);
    n_req_exp = 3;
    set_cs(H, H, ONE, 0, ONE, 0);
    run_case("stall5", mat(ONE, 0, 0, ONE, ONE, 0, 0, 0, ONE), 5, 0, 0, 0, 21, r_t2);

    // Positive saturation of R11; plane 3 skips.
    set_req(0, 2'd1, 16'h7000, 16'h7000, H, H);
    set_req(1, 2'd2, 16'h7FFF, 0, ONE, 0);
    n_req_exp = 2;
    set_cs(H, H, ONE, 0, ONE, 0);
    run_case("satpos", mat(16'h7000, 0, 0, 16'h7000, 0, 0, 0, 0, 0), 0, 0, 0, 0, 15,
             mat(16'h7FFF, 0, 0, 0, 0, 0, 0, 0, 0));

    // Negative saturation of R11.
    set_req(0, 2'd1, 16'h9000, 16'h9000, H, H);
    set_req(1, 2'd2, 16'h8000, 0, ONE, 0);
    n_req_exp = 2;
    set_cs(H, H, ONE, 0, ONE, 0);
    run_case("satneg", mat(16'h9000, 0, 0, 16'h9000, 0, 0, 0, 0, 0), 0, 0, 0, 0, 15,
             mat(16'h8000, 0, 0, 0, 0, 0, 0, 0, 0));

    // Spurious response in REQ plus a second start mid-run; 2-cycle stall.
    set_req(0, 2'd1, ONE, ONE, H, H);
    set_req(1, 2'd2, 16'h16A0, 0, ONE, 0);
    set_req(2, 2'd3, H, 0, ONE, 0);
    n_req_exp = 3;
    set_cs(H, H, ONE, 0, ONE, 0);
    run_case("spurious", mat(ONE, 0, 0, ONE, ONE, 0, 0, 0, ONE), 2, 1, 1, 0, 18, r_t2);

    // Reset during ROT of plane 2.
    run_case("midreset", mat(ONE, 0, 0, ONE, ONE, 0, 0, 0, ONE), 0, 0, 0, 9, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cs_rsp_valid = 1'b1;
    cs_rsp_cos = 16'h0777;
    cs_rsp_sin = 16'h0333;
    @(negedge clk);
    cs_rsp_valid = 1'b0;
    check("late_rsp_ignored", MW'({cos1, sin1, busy}), MW'({ONE, 16'h0000, 1'b0}));

    set_cs(H, H, ONE, 0, ONE, 0);
    run_case("after_reset", mat(ONE, 0, 0, ONE, ONE, 0, 0, 0, ONE), 0, 0, 0, 0, 16, r_t2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
